// File: rtl/slv_bus_regbank.sv
// Slave-bus endpoint behind the TLP engine's 16-bit slave port: a register bank on one BAR and
// a byte-enabled single-port RAM on another, sharing a fixed one-cycle registered read path.
module slv_bus_regbank #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned RAM_AW   = 13,
  parameter int unsigned LED_W    = 14,
  parameter logic [15:0] ID_VALUE = 16'h8010,
  parameter int unsigned REG_BAR  = 0,
  parameter int unsigned RAM_BAR  = 2
) (
  input  logic             clk_125,
  input  logic             rstn,
  input  logic [6:0]       slv_bar_i,
  input  logic             slv_ce_i,
  input  logic             slv_we_i,
  input  logic [19:1]      slv_adr_i,
  input  logic [15:0]      slv_dat_i,
  input  logic [1:0]       slv_sel_i,
  output logic [15:0]      slv_dat_o,
  input  logic [15:0]      event_i,
  output logic             irq_o,
  output logic [LED_W-1:0] led_out
);

  localparam int unsigned IdxW     = $clog2(NUM_REGS);
  localparam int unsigned RamDepth = 2 ** RAM_AW;
  localparam logic [8:0]  NumRegs9 = 9'(NUM_REGS);

  localparam logic [8:0] IdxLed     = 9'd0;
  localparam logic [8:0] IdxId      = 9'd1;
  localparam logic [8:0] IdxStatus  = 9'd2;
  localparam logic [8:0] IdxCounter = 9'd3;
  localparam logic [8:0] IdxMask    = 9'd4;

  function automatic logic [15:0] f_merge(input logic [15:0] old_val,
                                          input logic [15:0] new_val,
                                          input logic [1:0]  sel);
    return {sel[1] ? new_val[15:8] : old_val[15:8],
            sel[0] ? new_val[7:0]  : old_val[7:0]};
  endfunction

  // Access decode; REG_BAR takes priority when both BAR bits are set.
  logic w_reg_acc, w_ram_acc;
  logic w_reg_wr, w_reg_rd, w_ram_wr, w_ram_rd;

  assign w_reg_acc = slv_ce_i & slv_bar_i[REG_BAR];
  assign w_ram_acc = slv_ce_i & slv_bar_i[RAM_BAR] & ~slv_bar_i[REG_BAR];
  assign w_reg_wr  = w_reg_acc & slv_we_i;
  assign w_reg_rd  = w_reg_acc & ~slv_we_i;
  assign w_ram_wr  = w_ram_acc & slv_we_i;
  assign w_ram_rd  = w_ram_acc & ~slv_we_i;

  logic [8:0]      w_idx;
  logic [IdxW-1:0] w_sidx;
  logic            w_in_bank;
  logic            w_wr_led, w_wr_status, w_wr_cnt, w_wr_mask, w_wr_scr;
  logic [15:0]     w_byte_mask, w_status_clr;

  assign w_idx       = slv_adr_i[9:1];
  assign w_sidx      = w_idx[IdxW-1:0];
  assign w_in_bank   = (w_idx < NumRegs9);
  assign w_wr_led    = w_reg_wr & (w_idx == IdxLed);
  assign w_wr_status = w_reg_wr & (w_idx == IdxStatus);
  assign w_wr_cnt    = w_reg_wr & (w_idx == IdxCounter);
  assign w_wr_mask   = w_reg_wr & (w_idx == IdxMask);
  assign w_wr_scr    = w_reg_wr & w_in_bank & (w_idx > IdxMask);

  assign w_byte_mask  = {{8{slv_sel_i[1]}}, {8{slv_sel_i[0]}}};
  assign w_status_clr = w_wr_status ? (slv_dat_i & w_byte_mask) : 16'h0000;

  logic [LED_W-1:0] r_led;
  logic [15:0]      r_status, r_mask, r_counter;
  logic [15:0]      r_scratch [NUM_REGS];
  logic             r_irq;
  logic [15:0]      r_reg_q;
  logic             r_rd_ram;
  logic [15:0]      w_led_ext;
  logic [15:0]      w_reg_rdata;

  assign w_led_ext = 16'(r_led);

  always_comb begin
    w_reg_rdata = slv_adr_i[16:1];
    if (w_in_bank) begin
      case (w_idx)
        IdxLed:     w_reg_rdata = w_led_ext;
        IdxId:      w_reg_rdata = ID_VALUE;
        IdxStatus:  w_reg_rdata = r_status;
        IdxCounter: w_reg_rdata = r_counter;
        IdxMask:    w_reg_rdata = r_mask;
        default:    w_reg_rdata = r_scratch[w_sidx];
      endcase
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_led     <= '1;
      r_status  <= 16'h0000;
      r_mask    <= 16'h0000;
      r_counter <= 16'h0000;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_scratch[i] <= 16'h0000;
      end
      r_irq     <= 1'b0;
      r_reg_q   <= 16'h0000;
      r_rd_ram  <= 1'b0;
    end else begin
      if (w_wr_led) begin
        r_led <= LED_W'(f_merge(w_led_ext, slv_dat_i, slv_sel_i));
      end
      // Event set is OR'd in after the clear so a simultaneous set wins.
      r_status  <= (r_status & ~w_status_clr) | event_i;
      if (w_wr_mask) begin
        r_mask <= f_merge(r_mask, slv_dat_i, slv_sel_i);
      end
      r_counter <= w_wr_cnt ? 16'h0000 : r_counter + 16'd1;
      if (w_wr_scr) begin
        r_scratch[w_sidx] <= f_merge(r_scratch[w_sidx], slv_dat_i, slv_sel_i);
      end
      r_irq <= |(r_status & r_mask);
      if (w_reg_rd) begin
        r_reg_q <= w_reg_rdata;
      end
      // Output bank flag only moves on a qualified read, so writes keep slv_dat_o stable.
      if (w_reg_rd | w_ram_rd) begin
        r_rd_ram <= w_ram_rd;
      end
    end
  end

  // Inferred single-port RAM; upper address bits alias.
  logic [RAM_AW-1:0] w_ram_addr;
  logic [15:0]       r_mem [RamDepth];
  logic [15:0]       r_ram_q;

  assign w_ram_addr = slv_adr_i[RAM_AW:1];

  always_ff @(posedge clk_125) begin
    if (w_ram_wr) begin
      if (slv_sel_i[0]) begin
        r_mem[w_ram_addr][7:0] <= slv_dat_i[7:0];
      end
      if (slv_sel_i[1]) begin
        r_mem[w_ram_addr][15:8] <= slv_dat_i[15:8];
      end
    end
    if (w_ram_rd) begin
      r_ram_q <= r_mem[w_ram_addr];
    end
  end

  assign slv_dat_o = r_rd_ram ? r_ram_q : r_reg_q;
  assign irq_o     = r_irq;
  assign led_out   = r_led;

  logic w_unused;
  assign w_unused = ^{slv_adr_i[19:17], slv_bar_i};

endmodule

// File: tb/tb_slv_bus_regbank.sv
// Bench for slv_bus_regbank: vector table plus hand sequences for IRQ, counter and reset,
// with read data checked through an expected-value queue one cycle after each read strobe.
module tb_slv_bus_regbank;

  localparam logic [6:0] BarReg  = 7'b0000001;
  localparam logic [6:0] BarRam  = 7'b0000100;
  localparam logic [6:0] BarBoth = 7'b0000101;
  localparam logic [6:0] BarNone = 7'b0000010;

  logic        clk_125 = 1'b0;
  logic        rstn;
  logic [6:0]  slv_bar_i;
  logic        slv_ce_i;
  logic        slv_we_i;
  logic [19:1] slv_adr_i;
  logic [15:0] slv_dat_i;
  logic [1:0]  slv_sel_i;
  logic [15:0] slv_dat_o;
  logic [15:0] event_i;
  logic        irq_o;
  logic [13:0] led_out;

  always #4 clk_125 = ~clk_125;

  slv_bus_regbank dut (
    .clk_125   (clk_125),
    .rstn      (rstn),
    .slv_bar_i (slv_bar_i),
    .slv_ce_i  (slv_ce_i),
    .slv_we_i  (slv_we_i),
    .slv_adr_i (slv_adr_i),
    .slv_dat_i (slv_dat_i),
    .slv_sel_i (slv_sel_i),
    .slv_dat_o (slv_dat_o),
    .event_i   (event_i),
    .irq_o     (irq_o),
    .led_out   (led_out)
  );

  typedef struct {
    logic [15:0] exp;
    int          tol;
    string       name;
  } exp_t;

  typedef struct {
    logic        ce;
    logic [6:0]  bar;
    logic        we;
    logic [19:1] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        chk;
    logic [15:0] exp;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_pend;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp,
                       input int tol);
    int d;
    d = int'(act) - int'(exp);
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (tol %0d)", name, act, exp, tol);
    end
  endtask

  // A qualified read strobe seen at an edge is due on slv_dat_o by the following negedge.
  always @(posedge clk_125 or negedge rstn) begin
    if (!rstn) rd_pend <= 1'b0;
    else       rd_pend <= slv_ce_i && !slv_we_i && (slv_bar_i[0] || slv_bar_i[2]);
  end

  always @(negedge clk_125) begin : p_chk
    exp_t e;
    if (rd_pend) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: slv_dat_o=%h, no read expected", slv_dat_o);
      end else begin
        e = sb.pop_front();
        check(e.name, slv_dat_o, e.exp, e.tol);
      end
    end
  end

  task automatic step(input logic ce, input logic [6:0] bar, input logic we,
                      input logic [19:1] adr, input logic [15:0] dat, input logic [1:0] sel);
    slv_ce_i  = ce;
    slv_bar_i = bar;
    slv_we_i  = we;
    slv_adr_i = adr;
    slv_dat_i = dat;
    slv_sel_i = sel;
    @(negedge clk_125);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, BarNone, 1'b0, 19'd0, 16'h0000, 2'b00);
  endtask

  task automatic wr(input logic [6:0] bar, input logic [19:1] adr, input logic [15:0] dat,
                    input logic [1:0] sel);
    step(1'b1, bar, 1'b1, adr, dat, sel);
  endtask

  task automatic rd(input logic [6:0] bar, input logic [19:1] adr, input logic [15:0] exp,
                    input int tol, input string name);
    exp_t e;
    e.exp  = exp;
    e.tol  = tol;
    e.name = name;
    sb.push_back(e);
    step(1'b1, bar, 1'b0, adr, 16'h0000, 2'b00);
  endtask

  task automatic add(input logic ce, input logic [6:0] bar, input logic we,
                     input logic [19:1] adr, input logic [15:0] dat, input logic [1:0] sel,
                     input logic chk, input logic [15:0] exp, input string name);
    vec_t v;
    v.ce = ce; v.bar = bar; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.chk = chk; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin : p_watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    event_i = 16'h0000;
    slv_ce_i = 1'b0; slv_bar_i = BarNone; slv_we_i = 1'b0;
    slv_adr_i = 19'd0; slv_dat_i = 16'h0000; slv_sel_i = 2'b00;

    repeat (2) @(negedge clk_125);
    check("reset_dat", slv_dat_o, 16'h0000, 0);
    check("reset_irq", 16'(irq_o), 16'h0000, 0);
    check("reset_led", 16'(led_out), 16'h3FFF, 0);
    rstn = 1'b1;
    @(negedge clk_125);

    add(1, BarReg,  0, 19'd0,     16'h0000, 2'b00, 1, 16'h3FFF, "rd_led_reset");
    add(1, BarReg,  0, 19'd1,     16'h0000, 2'b00, 1, 16'h8010, "rd_id");
    add(1, BarReg,  1, 19'd0,     16'hABCD, 2'b01, 0, 16'h0000, "");
    add(1, BarReg,  0, 19'd0,     16'h0000, 2'b00, 1, 16'h3FCD, "rd_led_sel01");
    add(1, BarReg,  1, 19'd1,     16'hFFFF, 2'b11, 0, 16'h0000, "");
    add(1, BarReg,  0, 19'd1,     16'h0000, 2'b00, 1, 16'h8010, "rd_id_after_wr");
    add(1, BarRam,  1, 19'd5,     16'h1234, 2'b11, 0, 16'h0000, "");
    add(1, BarRam,  1, 19'd5,     16'h00EE, 2'b01, 0, 16'h0000, "");
    add(1, BarRam,  0, 19'd5,     16'h0000, 2'b00, 1, 16'h12EE, "rd_ram_be");
    add(1, BarRam,  0, 19'd8197,  16'h0000, 2'b00, 1, 16'h12EE, "rd_ram_alias");
    add(1, BarReg,  1, 19'd5,     16'hBEEF, 2'b11, 0, 16'h0000, "");
    add(1, BarReg,  0, 19'd5,     16'h0000, 2'b00, 1, 16'hBEEF, "rd_scratch5_raw");
    add(1, BarReg,  1, 19'd7,     16'h5566, 2'b10, 0, 16'h0000, "");
    add(1, BarReg,  0, 19'd7,     16'h0000, 2'b00, 1, 16'h5500, "rd_scratch7_sel10");
    add(1, BarRam,  1, 19'd0,     16'hCAFE, 2'b11, 0, 16'h0000, "");
    add(1, BarReg,  1, 19'd4,     16'h00F0, 2'b11, 0, 16'h0000, "");
    add(1, BarReg,  0, 19'd4,     16'h0000, 2'b00, 1, 16'h00F0, "rd_mask");
    add(1, BarRam,  0, 19'd0,     16'h0000, 2'b00, 1, 16'hCAFE, "rd_ram0");
    add(1, BarReg,  0, 19'h001F0, 16'h0000, 2'b00, 1, 16'h01F0, "rd_echo");
    add(1, BarRam,  1, 19'd6,     16'h1111, 2'b11, 0, 16'h0000, "");
    add(1, BarBoth, 1, 19'd6,     16'h7777, 2'b11, 0, 16'h0000, "");
    add(1, BarRam,  0, 19'd6,     16'h0000, 2'b00, 1, 16'h1111, "rd_ram6_both_bar");
    add(1, BarReg,  0, 19'd6,     16'h0000, 2'b00, 1, 16'h7777, "rd_scratch6_both_bar");
    add(1, BarRam,  1, 19'd9,     16'h2222, 2'b11, 0, 16'h0000, "");
    add(1, BarNone, 0, 19'd0,     16'h0000, 2'b00, 0, 16'h0000, "");
    add(0, BarReg,  0, 19'd1,     16'h0000, 2'b00, 0, 16'h0000, "");
    add(1, BarNone, 1, 19'd0,     16'h0000, 2'b11, 0, 16'h0000, "");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].chk) begin
        exp_t e;
        e.exp = vecs[i].exp; e.tol = 0; e.name = vecs[i].name;
        sb.push_back(e);
      end
      step(vecs[i].ce, vecs[i].bar, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
    end
    idle(1);
    check("dat_hold", slv_dat_o, 16'h7777, 0);
    check("led_hold", 16'(led_out), 16'h3FCD, 0);
    check("irq_idle", 16'(irq_o), 16'h0000, 0);

    // Interrupt status: set by event, masked, W1C with set priority.
    event_i = 16'h0005;
    idle(1);
    event_i = 16'h0000;
    wr(BarReg, 19'd4, 16'h0004, 2'b11);
    idle(1);
    check("irq_set", 16'(irq_o), 16'h0001, 0);
    rd(BarReg, 19'd2, 16'h0005, 0, "rd_status_set");
    event_i = 16'h0004;
    wr(BarReg, 19'd2, 16'h0004, 2'b11);
    event_i = 16'h0000;
    rd(BarReg, 19'd2, 16'h0005, 0, "rd_status_set_wins");
    check("irq_set_wins", 16'(irq_o), 16'h0001, 0);
    wr(BarReg, 19'd2, 16'h0004, 2'b11);
    check("irq_lag", 16'(irq_o), 16'h0001, 0);
    idle(1);
    check("irq_clear", 16'(irq_o), 16'h0000, 0);
    rd(BarReg, 19'd2, 16'h0001, 0, "rd_status_after_clr");
    wr(BarReg, 19'd2, 16'h0001, 2'b10);
    rd(BarReg, 19'd2, 16'h0001, 0, "rd_status_w1c_sel");
    wr(BarReg, 19'd2, 16'h0001, 2'b01);
    rd(BarReg, 19'd2, 16'h0000, 0, "rd_status_cleared");

    // Counter: any write clears it, read samples at the strobe.
    wr(BarReg, 19'd3, 16'h1234, 2'b00);
    idle(100);
    rd(BarReg, 19'd3, 16'd100, 1, "rd_counter");
    idle(1);

    // Asynchronous reset in the middle of a read burst.
    event_i = 16'h0004;
    idle(1);
    event_i = 16'h0000;
    idle(2);
    check("irq_before_reset", 16'(irq_o), 16'h0001, 0);
    rd(BarReg, 19'd0, 16'h3FCD, 0, "rd_led_burst");
    rd(BarRam, 19'd0, 16'hCAFE, 0, "rd_ram_burst");
    slv_ce_i = 1'b1; slv_bar_i = BarRam; slv_we_i = 1'b0; slv_adr_i = 19'd5;
    @(posedge clk_125);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_dat", slv_dat_o, 16'h0000, 0);
    check("async_reset_irq", 16'(irq_o), 16'h0000, 0);
    check("async_reset_led", 16'(led_out), 16'h3FFF, 0);
    sb.delete();
    slv_ce_i = 1'b0;
    @(negedge clk_125);
    rstn = 1'b1;
    @(negedge clk_125);
    rd(BarReg, 19'd0, 16'h3FFF, 0, "rd_led_after_reset");
    rd(BarReg, 19'd4, 16'h0000, 0, "rd_mask_after_reset");
    idle(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
